// File: rtl/aes128_ctrl_pkg.sv
// rtl/aes128_ctrl_pkg.sv - register map, bit indices and FSM states for the aes128 Wishbone controller
package aes128_ctrl_pkg;

    localparam logic [7:0] OFF_KEY    = 8'h00;
    localparam logic [7:0] OFF_STATE  = 8'h10;
    localparam logic [7:0] OFF_RESULT = 8'h20;
    localparam logic [7:0] OFF_CTRL   = 8'h30;
    localparam logic [7:0] OFF_STATUS = 8'h34;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_DONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } ctrl_state_t;

    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes128_wb_ctrl_if.sv
// rtl/aes128_wb_ctrl_if.sv - Wishbone slave bus bundle for the aes128 controller
interface aes128_wb_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/aes128_ctrl_regfile.sv
// rtl/aes128_ctrl_regfile.sv - bus decode, single-shot ack, register storage and readback
module aes128_ctrl_regfile
    import aes128_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    aes128_wb_ctrl_if.slave wb,
    input  logic           i_lock,
    input  logic           i_busy,
    input  logic           i_capture,
    input  logic [127:0]   i_aes_out,
    output logic [127:0]   o_key,
    output logic [127:0]   o_state,
    output logic           o_start,
    output logic           o_irq_en,
    output logic           o_done
);

    logic [31:0] r_key    [4];
    logic [31:0] r_state  [4];
    logic [31:0] r_result [4];
    logic        r_irq_en;
    logic        r_done;
    logic        r_ack;
    logic        r_hold;
    logic [31:0] r_dat_o;

    logic        w_sel;
    logic        w_acc;
    logic        w_wr;
    logic [7:0]  w_off;
    logic        w_aligned;
    logic        w_w1c;
    logic        w_ctrl_wr;
    logic [31:0] w_rdata;

    assign w_sel     = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // r_hold keeps a held select from earning a second ack until the master lets go
    assign w_acc     = w_sel & ~r_ack & ~r_hold;
    assign w_wr      = w_acc & wb.wbs_we_i;
    assign w_off     = wb.wbs_adr_i[7:0];
    assign w_aligned = (w_off[1:0] == 2'b00);
    assign w_ctrl_wr = w_wr && (w_off == OFF_CTRL) && wb.wbs_sel_i[0];
    assign o_start   = w_ctrl_wr && wb.wbs_dat_i[CTRL_START] && !i_lock;
    assign w_w1c     = w_wr && (w_off == OFF_STATUS) && wb.wbs_sel_i[0] && wb.wbs_dat_i[STATUS_DONE];

    always_comb begin
        w_rdata = '0;
        if (w_aligned) begin
            case (w_off[7:4])
                OFF_KEY[7:4]:    w_rdata = r_key[w_off[3:2]];
                OFF_STATE[7:4]:  w_rdata = r_state[w_off[3:2]];
                OFF_RESULT[7:4]: w_rdata = r_result[w_off[3:2]];
                default: begin
                    if (w_off == OFF_CTRL)   w_rdata[CTRL_IRQ_EN] = r_irq_en;
                    if (w_off == OFF_STATUS) begin
                        w_rdata[STATUS_BUSY] = i_busy;
                        w_rdata[STATUS_DONE] = r_done;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_key[i]    <= '0;
                r_state[i]  <= '0;
                r_result[i] <= '0;
            end
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_ack    <= 1'b0;
            r_hold   <= 1'b0;
            r_dat_o  <= '0;
        end else begin
            r_ack   <= w_acc;
            r_hold  <= w_sel & (r_hold | r_ack);
            r_dat_o <= w_acc ? w_rdata : '0;

            if (w_wr && !i_lock && w_aligned && (w_off[7:4] == OFF_KEY[7:4]))
                r_key[w_off[3:2]] <= apply_sel(r_key[w_off[3:2]], wb.wbs_dat_i, wb.wbs_sel_i);
            if (w_wr && !i_lock && w_aligned && (w_off[7:4] == OFF_STATE[7:4]))
                r_state[w_off[3:2]] <= apply_sel(r_state[w_off[3:2]], wb.wbs_dat_i, wb.wbs_sel_i);
            if (w_ctrl_wr)
                r_irq_en <= wb.wbs_dat_i[CTRL_IRQ_EN];

            if (i_capture) begin
                for (int i = 0; i < 4; i++) r_result[i] <= i_aes_out[(3-i)*32 +: 32];
            end

            // capture beats a same-edge W1C so a finished result is never lost
            if (i_capture)             r_done <= 1'b1;
            else if (o_start || w_w1c) r_done <= 1'b0;
        end
    end

    assign o_key        = {r_key[0], r_key[1], r_key[2], r_key[3]};
    assign o_state      = {r_state[0], r_state[1], r_state[2], r_state[3]};
    assign o_irq_en     = r_irq_en;
    assign o_done       = r_done;
    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat_o;

endmodule

// File: rtl/aes128_wb_ctrl.sv
// rtl/aes128_wb_ctrl.sv - sequences the pipelined aes128 core: start, latency count, capture
module aes128_wb_ctrl
    import aes128_ctrl_pkg::*;
#(
    parameter int          AES_LATENCY = 21,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    aes128_wb_ctrl_if.slave wb,
    output logic [127:0]    aes_key,
    output logic [127:0]    aes_state,
    input  logic [127:0]    aes_out,
    output logic            busy,
    output logic            irq
);

    localparam int CNT_W = $clog2(AES_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AES_LATENCY - 1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_start;
    logic             w_irq_en;
    logic             w_done;
    logic             w_lock;
    logic             w_capture;

    // inputs stay frozen through CAPTURE too, so the sampled output matches them
    assign w_lock    = (r_state != ST_IDLE);
    assign w_capture = (r_state == ST_CAPTURE);
    assign busy      = (r_state == ST_WAIT);
    assign irq       = w_done & w_irq_en;

    aes128_ctrl_regfile #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wb),
        .i_lock    (w_lock),
        .i_busy    (busy),
        .i_capture (w_capture),
        .i_aes_out (aes_out),
        .o_key     (aes_key),
        .o_state   (aes_state),
        .o_start   (w_start),
        .o_irq_en  (w_irq_en),
        .o_done    (w_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/aes128_wb_ctrl.md
Name: aes128_wb_ctrl

Overview:
- Wishbone-slave controller that sequences the pipelined aes128 core.
- Software loads a 128-bit key and a 128-bit state through registers, then writes START.
- The controller holds the core inputs stable, counts the core latency, captures the ciphertext, and raises DONE and an optional interrupt.
- Sits in user_project_wrapper between the Wishbone bus and the aes128 instance.

Parameters:
- AES_LATENCY, 21: clock edges from stable core inputs to a valid core output. Must be ≥1.
- BASE_ADDR, 32'h3000_0000: slave base address. Decode compares adr[31:8].

Ports:
- clk  in  1  system clock (wb_clk_i at top).
- rst_n  in  1  synchronous reset, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- aes_key  out  128  to core key.
- aes_state  out  128  to core state.
- aes_out  in  128  from core out.
- busy  out  1  operation in flight.
- irq  out  1  level interrupt = DONE & IRQ_EN.

Behaviour:
- Register map, offset = adr[7:0]:
  - 0x00–0x0C KEY0..3, RW. KEY0 = key[127:96].
  - 0x10–0x1C STATE0..3, RW, same ordering.
  - 0x20–0x2C RESULT0..3, RO.
  - 0x30 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN RW.
  - 0x34 STATUS: bit0 BUSY RO, bit1 DONE W1C.
  - Other offsets inside the window: read 0, write ignored, still acked.
- Bus handshake:
  - Select = cyc & stb & adr[31:8]==BASE_ADDR[31:8].
  - ack is registered: high one cycle after select, for exactly one cycle. Deasserted the following cycle even if select is held, so each access gets a single ack.
  - Writes commit on the edge that raises ack, with sel byte-masking.
  - wbs_dat_o is valid while ack is high and 0 otherwise.
  - No ack for addresses outside the window.
- aes_key / aes_state are driven continuously from the KEY / STATE registers.
- FSM IDLE → WAIT → CAPTURE → IDLE:
  - IDLE: a START commit at edge E0 moves to WAIT, with cnt=0 and BUSY=1.
  - WAIT: cnt increments each edge. When cnt==AES_LATENCY-1, go to CAPTURE (edge E0+L).
  - CAPTURE: RESULT ← aes_out, DONE=1, BUSY=0, back to IDLE (edge E0+L+1).
  - cnt width is $clog2(AES_LATENCY+1). The counter never wraps.
- While BUSY:
  - Writes to KEY/STATE are ignored (acked) so core inputs stay stable.
  - START is ignored.
  - CTRL.IRQ_EN and DONE W1C remain writable.
- A new START while DONE=1 is legal: DONE clears on the START commit.
- A DONE W1C on the same edge as CAPTURE: set wins, DONE=1.
- Reset (rst_n=0 at an edge):
  - All registers, RESULT, cnt, ack, dat_o, busy, irq → 0. FSM → IDLE.
  - Applies mid-operation too: the in-flight result is discarded.

Decomposition:
- Package aes128_ctrl_pkg: register offset localparams, CTRL/STATUS bit indices, FSM state enum.
- One sub-module, aes128_ctrl_regfile: bus decode, ack generation, register storage, readback mux.
- The top holds the FSM and counter.

Test Plan:
- FIPS-197 vector:
  - Stimulus: KEY=000102030405060708090a0b0c0d0e0f, STATE=00112233445566778899aabbccddeeff, START, stub core with latency 21.
  - Required: BUSY high for 21 cycles; DONE rises exactly 22 edges after the START ack; RESULT reads 69c4e0d86a7b0430d8cdb78070b4c55a.
- Bus protocol:
  - Hold cyc/stb for 4 cycles on a KEY1 write of 0xDEADBEEF with sel=4'b0011.
  - Required: exactly one ack; KEY1 low half = 0xBEEF, upper half unchanged; out-of-window address → no ack.
- Busy lockout:
  - During WAIT, write KEY0=0xFFFFFFFF and a second START.
  - Required: aes_key unchanged, the single op completes at the original time, only one CAPTURE.
- IRQ:
  - Set IRQ_EN=1 and run an op.
  - Required: irq rises with DONE. W1C to DONE drops irq the next cycle. A W1C on the CAPTURE edge leaves DONE=1.
- Reset mid-op:
  - Pull rst_n low for 1 cycle at cnt=10.
  - Required: busy=0, DONE=0, RESULT=0, all registers 0, no later capture.
